irq_pending_ctrl: RTL and testbench

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

---
 rtl/irq_pending_if.sv | 9 +
 rtl/irq_pending_ctrl.sv | 68 ++++++
 tb/tb_irq_pending_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/irq_pending_if.sv
// irq_pending_if: service handshake between the pending controller and its priority-encoder/consumer side.
interface irq_pending_if;
  logic [7:0] pend_o;
  logic       req_valid_o;
  logic [2:0] code_i;
  logic       ack_i;
  modport master (output pend_o, req_valid_o, input code_i, ack_i);
  modport slave  (input pend_o, req_valid_o, output code_i, ack_i);
endinterface

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: latches interrupt events, masks them, and hands them out one at a time with a post-ack holdoff.
module irq_pending_ctrl #(
  parameter int EDGE_MODE = 1,
  parameter int HOLDOFF   = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [7:0]     irq_i,
  input  logic           en_we_i,
  input  logic [7:0]     en_i,
  output logic [7:0]     ovf_o,
  input  logic           ovf_clr_i,
  irq_pending_if.master  bus
);
  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_e;
  localparam logic [3:0] HO = 4'(HOLDOFF);
  state_e     state_q, state_d;
  logic [7:0] irq_q, pend_q, pend_d, en_q, en_d, ovf_q, ovf_d, ev, clr, nxt;
  logic [3:0] cnt_q, cnt_d;
  logic       ack;
  assign ev              = (EDGE_MODE != 0) ? (irq_i & ~irq_q) : irq_i;
  assign bus.pend_o      = pend_q & en_q;
  assign bus.req_valid_o = state_q == PEND;
  assign ack             = bus.req_valid_o & bus.ack_i;
  assign clr             = (ack && bus.pend_o[bus.code_i]) ? (8'(1) << bus.code_i) : '0;
  // a new event on the bit being acked wins over the clear and is not an overflow
  assign pend_d          = (pend_q & ~clr) | ev;
  assign ovf_d           = (ovf_clr_i ? '0 : ovf_q) | (ev & pend_q & ~clr);
  assign en_d            = en_we_i ? en_i : en_q;
  assign nxt             = pend_d & en_d;
  assign ovf_o           = ovf_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = |bus.pend_o ? PEND : IDLE;
      PEND: begin
        if (ack && HO == 4'd0) state_d = |nxt ? PEND : IDLE;
        else if (ack) begin
          state_d = HOLD;
          cnt_d   = HO;
        end else if (!(|bus.pend_o)) state_d = IDLE;
      end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = |nxt ? PEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= '0;
      pend_q  <= '0;
      en_q    <= 8'hFF;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_i;
      pend_q  <= pend_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb_irq_pending_ctrl: directed checks of capture, priority drain, masking, overflow, collision and reset.
module tb_irq_pending_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni, en_we_i, ovf_clr_i, ack;
  logic [7:0] irq_i, en_i, ovf_o;
  int         n_tests = 0;
  int         n_fail  = 0;
  irq_pending_if bus();
  irq_pending_ctrl #(.EDGE_MODE(1), .HOLDOFF(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_i(irq_i), .en_we_i(en_we_i), .en_i(en_i),
    .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i), .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [2:0] enc(input logic [7:0] p);
    int r = 0;
    for (int i = 0; i < 8; i++) if (p[i]) r = i;
    return 3'(r);
  endfunction
  assign bus.code_i = enc(bus.pend_o);
  assign bus.ack_i  = ack;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_ni = 0; irq_i = 0; en_we_i = 0; en_i = 0; ovf_clr_i = 0; ack = 0;
    tick(); tick();
    rst_ni = 1;
    chk("rst_pend", bus.pend_o, 8'h00);
    chk("rst_rv", {7'd0, bus.req_valid_o}, 8'h00);
    chk("rst_ovf", ovf_o, 8'h00);
    irq_i = 8'h10; tick();
    chk("single_pend_t1", bus.pend_o, 8'h10);
    chk("single_rv_t1", {7'd0, bus.req_valid_o}, 8'h00);
    irq_i = 0; tick();
    chk("single_rv_t2", {7'd0, bus.req_valid_o}, 8'h01);
    chk("single_code", {5'd0, bus.code_i}, 8'h04);
    ack = 1; tick();
    chk("single_pend_ack", bus.pend_o, 8'h00);
    chk("single_hold1", {7'd0, bus.req_valid_o}, 8'h00);
    ack = 0; tick();
    chk("single_hold2", {7'd0, bus.req_valid_o}, 8'h00);
    tick();
    chk("single_idle", {7'd0, bus.req_valid_o}, 8'h00);
    irq_i = 8'h81; tick();
    chk("drain_pend", bus.pend_o, 8'h81);
    irq_i = 0; tick();
    chk("drain_rv1", {7'd0, bus.req_valid_o}, 8'h01);
    chk("drain_code7", {5'd0, bus.code_i}, 8'h07);
    ack = 1; tick();
    chk("drain_pend_b7", bus.pend_o, 8'h01);
    chk("drain_gap1", {7'd0, bus.req_valid_o}, 8'h00);
    ack = 0; tick();
    chk("drain_gap2", {7'd0, bus.req_valid_o}, 8'h00);
    tick();
    chk("drain_rv2", {7'd0, bus.req_valid_o}, 8'h01);
    chk("drain_code0", {5'd0, bus.code_i}, 8'h00);
    ack = 1; tick();
    chk("drain_pend_b0", bus.pend_o, 8'h00);
    ack = 0; tick(); tick();
    chk("drain_idle", {7'd0, bus.req_valid_o}, 8'h00);
    en_we_i = 1; en_i = 8'hFE; tick();
    en_we_i = 0; irq_i = 8'h01; tick();
    chk("mask_pend", bus.pend_o, 8'h00);
    irq_i = 0; tick();
    chk("mask_rv", {7'd0, bus.req_valid_o}, 8'h00);
    en_we_i = 1; en_i = 8'hFF; tick();
    chk("unmask_pend", bus.pend_o, 8'h01);
    chk("unmask_rv0", {7'd0, bus.req_valid_o}, 8'h00);
    en_we_i = 0; tick();
    chk("unmask_rv1", {7'd0, bus.req_valid_o}, 8'h01);
    ack = 1; tick();
    ack = 0; tick(); tick();
    chk("mask_drained", bus.pend_o, 8'h00);
    irq_i = 8'h08; tick();
    irq_i = 0; tick();
    chk("ovf_rv", {7'd0, bus.req_valid_o}, 8'h01);
    irq_i = 8'h08; tick();
    chk("ovf_set", ovf_o, 8'h08);
    chk("ovf_pend", bus.pend_o, 8'h08);
    irq_i = 0; tick();
    irq_i = 8'h08; ovf_clr_i = 1; tick();
    chk("ovf_clr_vs_new", ovf_o, 8'h08);
    irq_i = 0; tick();
    chk("ovf_clr", ovf_o, 8'h00);
    ovf_clr_i = 0; ack = 1; tick();
    ack = 0; tick(); tick();
    chk("ovf_drained", bus.pend_o, 8'h00);
    irq_i = 8'h04; tick();
    irq_i = 0; tick();
    chk("coll_rv", {7'd0, bus.req_valid_o}, 8'h01);
    ack = 1; irq_i = 8'h04; tick();
    chk("coll_pend", bus.pend_o, 8'h04);
    chk("coll_ovf", ovf_o, 8'h00);
    chk("coll_hold", {7'd0, bus.req_valid_o}, 8'h00);
    ack = 0; irq_i = 0; tick(); tick();
    chk("coll_repend", {7'd0, bus.req_valid_o}, 8'h01);
    irq_i = 8'h04; tick();
    chk("pre_rst_ovf", ovf_o, 8'h04);
    irq_i = 0; ack = 1; tick();
    ack = 0; irq_i = 8'h0C; en_we_i = 1; en_i = 8'h0F; tick();
    chk("pre_rst_pend", bus.pend_o, 8'h0C);
    chk("pre_rst_hold", {7'd0, bus.req_valid_o}, 8'h00);
    en_we_i = 0; rst_ni = 0; irq_i = 8'h80; tick();
    chk("midrst_pend", bus.pend_o, 8'h00);
    chk("midrst_ovf", ovf_o, 8'h00);
    chk("midrst_rv", {7'd0, bus.req_valid_o}, 8'h00);
    rst_ni = 1; tick();
    chk("post_rst_pend", bus.pend_o, 8'h80);
    irq_i = 0; tick();
    chk("post_rst_rv", {7'd0, bus.req_valid_o}, 8'h01);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
